xpt_sequencer: RTL and testbench
================================

# xpt_sequencer

Timing-state sequencer and opcode latch at the head of the instruction decoder. Generates the 5-bit T-state counter `XPT` and the latched opcode `Source`, with complementary rails (`notXPT`, `notSource`) and a decode enable, all consumed directly by the per-opcode `DECODER_op_*` blocks. It restarts the counter on the decoders' `PR_Reset_XPT` strobe and tracks CB/ED/DD/FD prefix bytes across re-fetches.

## Interface

- `FETCH_T`, 2: XPT value in whose cycle the opcode byte is sampled from `DataIn`.
- `MAX_XPT`, 23: highest legal XPT value; advancing past it is a fault.

- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `Wait` input 1: memory wait; high freezes XPT and suppresses the opcode latch.
- `PR_Reset_XPT` input 1: instruction-complete strobe (OR of all decoder `PR_Reset_XPT` outputs).
- `DataIn` input 8: data bus, sampled at opcode fetch.
- `XPT` output 5: current T-state.
- `notXPT` output 5: bitwise complement of `XPT`.
- `Source` output 8: latched opcode.
- `notSource` output 8: bitwise complement of `Source`.
- `DecodeEnable` output 1: drives decoder `enable` inputs.
- `M1` output 1: opcode-fetch phase indicator.
- `Prefix_CB`, `Prefix_ED`, `Prefix_IX`, `Prefix_IY` output 1 each: active prefix flags.
- `Fault` output 1: sticky T-state overrun.

## Operation

- Reset values: `XPT`=0, `notXPT`=5'h1F, `Source`=8'h00, `notSource`=8'hFF, all prefix flags 0, `Fault`=0, `DecodeEnable`=0, `M1`=1.
- Edge priority, highest first: `reset` > `Fault` held > `PR_Reset_XPT` > `Wait` > fetch or increment.
- `PR_Reset_XPT`=1: `XPT`←0 and all prefix flags cleared. `Wait` is ignored. If this coincides with `XPT`==`FETCH_T`, the fetch byte is discarded.
- `Wait`=1, with no higher-priority event: all state holds.
- `XPT`!=`FETCH_T`, `XPT`<`MAX_XPT`: `XPT`←`XPT`+1.
- `XPT`==`FETCH_T`, `Wait`=0, `DataIn` is not a prefix byte: `Source`←`DataIn` and `XPT`←`FETCH_T`+1.
- `XPT`==`FETCH_T`, `DataIn` is a prefix byte: `Source` holds, `XPT`←0 to re-fetch, and flags update as follows:
  - CB: set `Prefix_CB`; IX and IY are kept (DDCB/FDCB).
  - ED: set `Prefix_ED`; clear IX and IY.
  - DD: set `Prefix_IX`; clear IY and CB.
  - FD: set `Prefix_IY`; clear IX and CB.
  - Repeated DD/FD bytes: the last one wins.
- Prefix detection is suppressed while `Prefix_CB` or `Prefix_ED` is already set. The next byte is then always latched as the opcode, which covers DDCB displacement handling and ED DD.
- Overrun: `XPT`==`MAX_XPT` with an increment due sets `Fault`; `XPT` holds at `MAX_XPT`.
  - `Fault` is sticky and cleared only by `reset`.
  - While `Fault`=1, `PR_Reset_XPT`, `Wait` and `DataIn` are ignored.
- Combinational outputs:
  - `DecodeEnable` = (`XPT`>`FETCH_T`) & ~`Fault`.
  - `M1` = (`XPT`<=`FETCH_T`) & ~`Fault`.
  - `notXPT` = ~`XPT` and `notSource` = ~`Source`, bit-exact and registered alongside their true rails, with no skew between the pair.

## Timing

- Opcode latency: a byte presented during the `XPT`==`FETCH_T` cycle appears on `Source` in the next cycle, together with `XPT`=`FETCH_T`+1 and `DecodeEnable`=1.
- Every `Wait` cycle in the fetch window delays the latch by exactly one cycle.
- A prefix costs `FETCH_T`+1 cycles. The flag is visible in the cycle when `XPT` returns to 0.
- `PR_Reset_XPT` asserted in cycle n gives `XPT`=0, `M1`=1 and `DecodeEnable`=0 in cycle n+1.
- Minimum instruction loop: `FETCH_T`+2 cycles.
- `reset` mid-instruction behaves identically to power-on reset in the following cycle.

## Test plan

- Reset, then NOP stream (`DataIn`=8'h00), with `PR_Reset_XPT` asserted at `XPT`=4 -> `XPT` sequence 0,1,2,3,4,0; `DecodeEnable` high only at `XPT`=3,4; `notXPT` is always the complement of `XPT`.
- `DataIn`=8'hC9 (RET) at `XPT`=2, `PR_Reset_XPT` pulsed at `XPT`=9 -> `Source`=8'hC9 and `notSource`=8'h36 from `XPT`=3; `XPT` returns to 0 after `XPT`=9.
- `Wait` high for 3 cycles while `XPT`=2 -> `XPT` holds at 2 for 4 cycles and `Source` does not change until the edge where `Wait`=0.
- Byte sequence DD, CB, 8'h05, 8'h06 in successive fetch windows -> after the first two bytes, `Prefix_IX`=1 and `Prefix_CB`=1; 8'h05 is latched into `Source` (no prefix detection while CB is set); `PR_Reset_XPT` then clears both flags.
- `PR_Reset_XPT` and `Wait` both high at `XPT`=2 with `DataIn`=8'hFD -> next cycle `XPT`=0, `Prefix_IY`=0, `Source` unchanged.
- `PR_Reset_XPT` never asserted -> `Fault`=1 on the edge after `XPT`=23; `XPT` stays at 23; `DecodeEnable`=0 and `M1`=0; a later `PR_Reset_XPT` has no effect; `reset` clears the fault.

Source files
------------

// File: rtl/xpt_sequencer_if.sv
// xpt_sequencer_if
//   Bundles the sequencer's bus-side signals into one interface.
//   master : drives Wait / PR_Reset_XPT / DataIn and observes the T-state,
//            opcode and prefix outputs (testbench or upstream fetch logic).
//   slave  : the sequencer itself.
//   Signals:
//     Wait, PR_Reset_XPT, DataIn[7:0]            -> into the sequencer
//     XPT[4:0], notXPT[4:0], Source[7:0],
//     notSource[7:0], DecodeEnable, M1,
//     Prefix_CB, Prefix_ED, Prefix_IX, Prefix_IY,
//     Fault                                      <- out of the sequencer
interface xpt_sequencer_if;
    logic       Wait;
    logic       PR_Reset_XPT;
    logic [7:0] DataIn;
    logic [4:0] XPT;
    logic [4:0] notXPT;
    logic [7:0] Source;
    logic [7:0] notSource;
    logic       DecodeEnable;
    logic       M1;
    logic       Prefix_CB;
    logic       Prefix_ED;
    logic       Prefix_IX;
    logic       Prefix_IY;
    logic       Fault;

    modport master (
        output Wait, PR_Reset_XPT, DataIn,
        input  XPT, notXPT, Source, notSource, DecodeEnable, M1,
               Prefix_CB, Prefix_ED, Prefix_IX, Prefix_IY, Fault
    );

    modport slave (
        input  Wait, PR_Reset_XPT, DataIn,
        output XPT, notXPT, Source, notSource, DecodeEnable, M1,
               Prefix_CB, Prefix_ED, Prefix_IX, Prefix_IY, Fault
    );
endinterface

// File: rtl/xpt_sequencer.sv
// xpt_sequencer
//   T-state counter and opcode latch at the head of the instruction decoder.
//   XPT counts T-states; the opcode byte is sampled from DataIn while
//   XPT == FETCH_T. CB/ED/DD/FD prefix bytes restart the count (re-fetch)
//   and are remembered in the Prefix_* flags until PR_Reset_XPT ends the
//   instruction. Running past MAX_XPT sets a sticky Fault.
//   Ports:
//     clock  : rising-edge clock
//     reset  : synchronous, active-high
//     bus    : xpt_sequencer_if.slave (handshake inputs, state outputs)
//   Parameters:
//     FETCH_T : XPT value of the opcode fetch cycle
//     MAX_XPT : highest legal XPT value
module xpt_sequencer #(
    parameter int FETCH_T = 2,
    parameter int MAX_XPT = 23
) (
    input  logic           clock,
    input  logic           reset,
    xpt_sequencer_if.slave bus
);
    localparam logic [4:0] FT = 5'(FETCH_T);
    localparam logic [4:0] MX = 5'(MAX_XPT);

    localparam logic [7:0] OP_CB = 8'hCB;
    localparam logic [7:0] OP_ED = 8'hED;
    localparam logic [7:0] OP_DD = 8'hDD;
    localparam logic [7:0] OP_FD = 8'hFD;

    logic [4:0] xpt_q, xpt_d;
    logic [4:0] nxpt_q;
    logic [7:0] src_q, src_d;
    logic [7:0] nsrc_q;
    logic       cb_q, cb_d;
    logic       ed_q, ed_d;
    logic       ix_q, ix_d;
    logic       iy_q, iy_d;
    logic       fault_q, fault_d;
    logic       is_pfx;

    // Once CB or ED is active the next byte is always the opcode (covers the
    // DDCB displacement byte and ED followed by DD/FD).
    assign is_pfx = ~(cb_q | ed_q) &
                    ((bus.DataIn == OP_CB) || (bus.DataIn == OP_ED) ||
                     (bus.DataIn == OP_DD) || (bus.DataIn == OP_FD));

    always_comb begin
        xpt_d   = xpt_q;
        src_d   = src_q;
        cb_d    = cb_q;
        ed_d    = ed_q;
        ix_d    = ix_q;
        iy_d    = iy_q;
        fault_d = fault_q;
        if (fault_q) begin
            // frozen until reset
        end else if (bus.PR_Reset_XPT) begin
            xpt_d = '0;
            cb_d  = 1'b0;
            ed_d  = 1'b0;
            ix_d  = 1'b0;
            iy_d  = 1'b0;
        end else if (bus.Wait) begin
            // memory wait: hold everything
        end else if (xpt_q == FT) begin
            if (is_pfx) begin
                xpt_d = '0;
                case (bus.DataIn)
                    OP_CB:   cb_d = 1'b1;
                    OP_ED:   begin ed_d = 1'b1; ix_d = 1'b0; iy_d = 1'b0; end
                    OP_DD:   begin ix_d = 1'b1; iy_d = 1'b0; cb_d = 1'b0; end
                    default: begin iy_d = 1'b1; ix_d = 1'b0; cb_d = 1'b0; end
                endcase
            end else begin
                src_d = bus.DataIn;
                xpt_d = FT + 5'd1;
            end
        end else if (xpt_q < MX) begin
            xpt_d = xpt_q + 5'd1;
        end else begin
            // increment due at MAX_XPT: overrun, XPT holds
            fault_d = 1'b1;
        end
    end

    // Complement rails are separate flops loaded from the same next-state,
    // so each pair changes on the same edge with no combinational skew.
    always_ff @(posedge clock) begin
        if (reset) begin
            xpt_q   <= '0;
            nxpt_q  <= 5'h1F;
            src_q   <= '0;
            nsrc_q  <= 8'hFF;
            cb_q    <= 1'b0;
            ed_q    <= 1'b0;
            ix_q    <= 1'b0;
            iy_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            xpt_q   <= xpt_d;
            nxpt_q  <= ~xpt_d;
            src_q   <= src_d;
            nsrc_q  <= ~src_d;
            cb_q    <= cb_d;
            ed_q    <= ed_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            fault_q <= fault_d;
        end
    end

    assign bus.XPT          = xpt_q;
    assign bus.notXPT       = nxpt_q;
    assign bus.Source       = src_q;
    assign bus.notSource    = nsrc_q;
    assign bus.Prefix_CB    = cb_q;
    assign bus.Prefix_ED    = ed_q;
    assign bus.Prefix_IX    = ix_q;
    assign bus.Prefix_IY    = iy_q;
    assign bus.Fault        = fault_q;
    assign bus.DecodeEnable = (xpt_q > FT) & ~fault_q;
    assign bus.M1           = (xpt_q <= FT) & ~fault_q;
endmodule

// File: tb/tb_xpt_sequencer.sv
// tb_xpt_sequencer
//   Directed-vector bench for xpt_sequencer (FETCH_T=2, MAX_XPT=23).
//   Inputs change 1 time unit after a rising edge; outputs are sampled
//   at that same point, i.e. showing the state produced by the last edge.
module tb_xpt_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    xpt_sequencer_if bus ();

    xpt_sequencer #(.FETCH_T(2), .MAX_XPT(23)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.Wait = 1'b0; bus.PR_Reset_XPT = 1'b0; bus.DataIn = 8'h00;
        step(); step();
        reset = 1'b0;
        if (bus.XPT !== 5'd0) begin $display("FAIL reset_xpt got %0h exp 0", bus.XPT); n_err++; end n_cmp++;
        if (bus.notXPT !== 5'h1F) begin $display("FAIL reset_notxpt got %0h exp 1f", bus.notXPT); n_err++; end n_cmp++;
        if (bus.Source !== 8'h00) begin $display("FAIL reset_src got %0h exp 0", bus.Source); n_err++; end n_cmp++;
        if (bus.notSource !== 8'hFF) begin $display("FAIL reset_nsrc got %0h exp ff", bus.notSource); n_err++; end n_cmp++;
        if ({bus.Prefix_CB, bus.Prefix_ED, bus.Prefix_IX, bus.Prefix_IY} !== 4'b0000) begin
            $display("FAIL reset_prefix got %b exp 0000", {bus.Prefix_CB, bus.Prefix_ED, bus.Prefix_IX, bus.Prefix_IY}); n_err++; end n_cmp++;
        if ({bus.Fault, bus.DecodeEnable, bus.M1} !== 3'b001) begin
            $display("FAIL reset_ctl got %b exp 001", {bus.Fault, bus.DecodeEnable, bus.M1}); n_err++; end n_cmp++;
    endtask

    // NOP stream, instruction ends at XPT=4
    task automatic test_nop();
        bus.DataIn = 8'h00;
        for (int i = 0; i <= 4; i++) begin
            if (bus.XPT !== 5'(i)) begin $display("FAIL nop_xpt got %0d exp %0d", bus.XPT, i); n_err++; end n_cmp++;
            if (bus.notXPT !== ~5'(i)) begin $display("FAIL nop_notxpt got %0h exp %0h", bus.notXPT, ~5'(i)); n_err++; end n_cmp++;
            if (bus.DecodeEnable !== (i > 2)) begin $display("FAIL nop_de got %b exp %b at xpt %0d", bus.DecodeEnable, (i > 2), i); n_err++; end n_cmp++;
            if (bus.M1 !== (i <= 2)) begin $display("FAIL nop_m1 got %b exp %b at xpt %0d", bus.M1, (i <= 2), i); n_err++; end n_cmp++;
            if (i == 4) bus.PR_Reset_XPT = 1'b1;
            step();
        end
        bus.PR_Reset_XPT = 1'b0;
        if ({bus.XPT, bus.M1, bus.DecodeEnable} !== {5'd0, 1'b1, 1'b0}) begin
            $display("FAIL nop_restart got xpt=%0d m1=%b de=%b exp 0 1 0", bus.XPT, bus.M1, bus.DecodeEnable); n_err++; end n_cmp++;
    endtask

    // RET latched at XPT=2, instruction ends at XPT=9
    task automatic test_ret();
        step(); step();
        bus.DataIn = 8'hC9;
        step();
        bus.DataIn = 8'h00;
        if ({bus.XPT, bus.DecodeEnable} !== {5'd3, 1'b1}) begin $display("FAIL ret_lat got xpt=%0d de=%b exp 3 1", bus.XPT, bus.DecodeEnable); n_err++; end n_cmp++;
        for (int i = 3; i <= 9; i++) begin
            if ({bus.Source, bus.notSource} !== 16'hC936) begin $display("FAIL ret_src got %0h/%0h exp c9/36", bus.Source, bus.notSource); n_err++; end n_cmp++;
            if (i == 9) bus.PR_Reset_XPT = 1'b1;
            step();
        end
        bus.PR_Reset_XPT = 1'b0;
        if (bus.XPT !== 5'd0) begin $display("FAIL ret_end got %0d exp 0", bus.XPT); n_err++; end n_cmp++;
    endtask

    // three wait cycles in the fetch window
    task automatic test_wait();
        step(); step();
        bus.DataIn = 8'h3E;
        bus.Wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if ({bus.XPT, bus.Source} !== {5'd2, 8'hC9}) begin $display("FAIL wait_hold got xpt=%0d src=%0h exp 2 c9", bus.XPT, bus.Source); n_err++; end n_cmp++;
        end
        bus.Wait = 1'b0;
        step();
        if ({bus.XPT, bus.Source, bus.notSource} !== {5'd3, 8'h3E, 8'hC1}) begin
            $display("FAIL wait_lat got xpt=%0d src=%0h nsrc=%0h exp 3 3e c1", bus.XPT, bus.Source, bus.notSource); n_err++; end n_cmp++;
        bus.PR_Reset_XPT = 1'b1; step(); bus.PR_Reset_XPT = 1'b0;
    endtask

    // fetch one byte at XPT=2 starting from XPT=0
    task automatic fetch(input logic [7:0] b);
        step(); step();
        bus.DataIn = b;
        step();
        bus.DataIn = 8'h00;
    endtask

    task automatic test_prefix();
        fetch(8'hDD);
        if ({bus.XPT, bus.Prefix_IX, bus.Prefix_CB, bus.Source} !== {5'd0, 1'b1, 1'b0, 8'h3E}) begin
            $display("FAIL pfx_dd got xpt=%0d ix=%b cb=%b src=%0h exp 0 1 0 3e", bus.XPT, bus.Prefix_IX, bus.Prefix_CB, bus.Source); n_err++; end n_cmp++;
        fetch(8'hCB);
        if ({bus.XPT, bus.Prefix_IX, bus.Prefix_CB} !== {5'd0, 1'b1, 1'b1}) begin
            $display("FAIL pfx_ddcb got xpt=%0d ix=%b cb=%b exp 0 1 1", bus.XPT, bus.Prefix_IX, bus.Prefix_CB); n_err++; end n_cmp++;
        fetch(8'h05);
        if ({bus.XPT, bus.Source, bus.Prefix_IX, bus.Prefix_CB} !== {5'd3, 8'h05, 1'b1, 1'b1}) begin
            $display("FAIL pfx_disp got xpt=%0d src=%0h ix=%b cb=%b exp 3 05 1 1", bus.XPT, bus.Source, bus.Prefix_IX, bus.Prefix_CB); n_err++; end n_cmp++;
        bus.PR_Reset_XPT = 1'b1; step(); bus.PR_Reset_XPT = 1'b0;
        if ({bus.Prefix_IX, bus.Prefix_CB} !== 2'b00) begin $display("FAIL pfx_clr got %b exp 00", {bus.Prefix_IX, bus.Prefix_CB}); n_err++; end n_cmp++;
        fetch(8'h06);
        if ({bus.XPT, bus.Source} !== {5'd3, 8'h06}) begin $display("FAIL pfx_06 got xpt=%0d src=%0h exp 3 06", bus.XPT, bus.Source); n_err++; end n_cmp++;
        bus.PR_Reset_XPT = 1'b1; step(); bus.PR_Reset_XPT = 1'b0;
        // ED then DD: DD is the opcode, IX untouched
        fetch(8'hED);
        fetch(8'hDD);
        if ({bus.XPT, bus.Source, bus.Prefix_ED, bus.Prefix_IX} !== {5'd3, 8'hDD, 1'b1, 1'b0}) begin
            $display("FAIL pfx_eddd got xpt=%0d src=%0h ed=%b ix=%b exp 3 dd 1 0", bus.XPT, bus.Source, bus.Prefix_ED, bus.Prefix_IX); n_err++; end n_cmp++;
        bus.PR_Reset_XPT = 1'b1; step(); bus.PR_Reset_XPT = 1'b0;
        // DD then FD: last one wins
        fetch(8'hDD);
        fetch(8'hFD);
        if ({bus.Prefix_IX, bus.Prefix_IY, bus.Prefix_ED} !== 3'b010) begin
            $display("FAIL pfx_ddfd got ix/iy/ed=%b exp 010", {bus.Prefix_IX, bus.Prefix_IY, bus.Prefix_ED}); n_err++; end n_cmp++;
        bus.PR_Reset_XPT = 1'b1; step(); bus.PR_Reset_XPT = 1'b0;
    endtask

    // PR_Reset_XPT beats Wait and discards the fetch byte
    task automatic test_pr_wait();
        step(); step();
        bus.PR_Reset_XPT = 1'b1; bus.Wait = 1'b1; bus.DataIn = 8'hFD;
        step();
        bus.PR_Reset_XPT = 1'b0; bus.Wait = 1'b0; bus.DataIn = 8'h00;
        if ({bus.XPT, bus.Prefix_IY, bus.Source} !== {5'd0, 1'b0, 8'hDD}) begin
            $display("FAIL prw got xpt=%0d iy=%b src=%0h exp 0 0 dd", bus.XPT, bus.Prefix_IY, bus.Source); n_err++; end n_cmp++;
    endtask

    task automatic test_fault();
        bus.DataIn = 8'h12;
        for (int i = 0; i < 23; i++) step();
        if ({bus.XPT, bus.Fault, bus.DecodeEnable, bus.Source} !== {5'd23, 1'b0, 1'b1, 8'h12}) begin
            $display("FAIL flt_pre got xpt=%0d f=%b de=%b src=%0h exp 23 0 1 12", bus.XPT, bus.Fault, bus.DecodeEnable, bus.Source); n_err++; end n_cmp++;
        step();
        if ({bus.XPT, bus.Fault, bus.DecodeEnable, bus.M1} !== {5'd23, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL flt_set got xpt=%0d f=%b de=%b m1=%b exp 23 1 0 0", bus.XPT, bus.Fault, bus.DecodeEnable, bus.M1); n_err++; end n_cmp++;
        bus.PR_Reset_XPT = 1'b1; bus.DataIn = 8'h77;
        step(); step();
        bus.PR_Reset_XPT = 1'b0;
        if ({bus.XPT, bus.Fault, bus.Source, bus.notXPT} !== {5'd23, 1'b1, 8'h12, 5'h08}) begin
            $display("FAIL flt_sticky got xpt=%0d f=%b src=%0h nx=%0h exp 23 1 12 08", bus.XPT, bus.Fault, bus.Source, bus.notXPT); n_err++; end n_cmp++;
        reset = 1'b1; step(); reset = 1'b0;
        if ({bus.XPT, bus.Fault, bus.M1, bus.Source} !== {5'd0, 1'b0, 1'b1, 8'h00}) begin
            $display("FAIL flt_clr got xpt=%0d f=%b m1=%b src=%0h exp 0 0 1 00", bus.XPT, bus.Fault, bus.M1, bus.Source); n_err++; end n_cmp++;
    endtask

    initial begin
        bus.Wait = 1'b0; bus.PR_Reset_XPT = 1'b0; bus.DataIn = 8'h00;
        test_reset();
        test_nop();
        test_ret();
        test_wait();
        test_prefix();
        test_pr_wait();
        test_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
